// File: rtl/dma_wr_engine.sv
// dma_wr_engine: buffers AFU cache lines in a FIFO and issues one memory write per line, counting acks to completion.
module dma_wr_engine #(
  parameter int ADDR_WIDTH = 64,
  parameter int SIZE_WIDTH = 43,
  parameter int DATA_WIDTH = 512,
  parameter int FIFO_DEPTH = 16,
  parameter int MAX_OUTSTANDING = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_go,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [SIZE_WIDTH-1:0] wr_size,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  wr_done,
  output logic                  mem_wr_req_valid,
  output logic [ADDR_WIDTH-7:0] mem_wr_req_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_req_data,
  input  logic                  mem_wr_almost_full,
  input  logic                  mem_wr_rsp_valid
);
  localparam int LW = ADDR_WIDTH - 6;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;
  state_t state;
  logic [LW-1:0] base;
  logic [SIZE_WIDTH-1:0] size_r, acc_cnt, iss_cnt, rsp_cnt;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] cnt, cnt_next;
  logic go, push, pop, rsp, fin;
  logic unused_ok;
  assign unused_ok = ^wr_addr[5:0];
  always_comb begin
    go = wr_go && state != ACTIVE;
    push = wr_en && state == ACTIVE && !full && acc_cnt < size_r;
    pop = cnt != '0 && !mem_wr_almost_full && state == ACTIVE &&
          (iss_cnt - rsp_cnt) < SIZE_WIDTH'(MAX_OUTSTANDING);
    rsp = mem_wr_rsp_valid && state == ACTIVE && rsp_cnt < iss_cnt;
    // look ahead one response so wr_done rises the cycle after the last ack
    fin = state == ACTIVE && (rsp_cnt + SIZE_WIDTH'(rsp)) == size_r;
    cnt_next = cnt + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= wr_data;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      base <= '0;
      size_r <= '0;
      acc_cnt <= '0;
      iss_cnt <= '0;
      rsp_cnt <= '0;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      full <= 1'b0;
      wr_done <= 1'b0;
      mem_wr_req_valid <= 1'b0;
      mem_wr_req_addr <= '0;
      mem_wr_req_data <= '0;
    end else begin
      mem_wr_req_valid <= pop;
      if (pop) begin
        mem_wr_req_addr <= base + LW'(iss_cnt);
        mem_wr_req_data <= mem[rp];
        rp <= rp + 1'b1;
        iss_cnt <= iss_cnt + 1'b1;
      end
      if (push) begin
        wp <= wp + 1'b1;
        acc_cnt <= acc_cnt + 1'b1;
      end
      if (rsp) rsp_cnt <= rsp_cnt + 1'b1;
      cnt <= cnt_next;
      full <= cnt_next == CW'(FIFO_DEPTH);
      if (go) begin
        state <= ACTIVE;
        base <= wr_addr[ADDR_WIDTH-1:6];
        size_r <= wr_size;
        acc_cnt <= '0;
        iss_cnt <= '0;
        rsp_cnt <= '0;
        wr_done <= 1'b0;
      end else if (fin) begin
        state <= DONE;
        wr_done <= 1'b1;
      end
    end
  end
endmodule
